// File: rtl/handshake_data_sync.sv
// rtl/handshake_data_sync.sv - 4-phase req/ack data synchronizer into the clk domain
// Only the request crosses through flops; the bus is sampled once req_s has settled.
module handshake_data_sync #(
   parameter int NUM_STAGES = 2,
   parameter int BUS_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 unsync_req,
   input  logic [BUS_WIDTH-1:0] unsync_bus,
   output logic [BUS_WIDTH-1:0] sync_bus,
   output logic                 enable_pulse,
   output logic                 ack,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CAPTURE  = 2'd1,
      WAIT_LOW = 2'd2
   } state_e;

   state_e                state_q;
   state_e                state_d;
   logic [NUM_STAGES-1:0] sync_q;
   logic                  req_s;
   logic [BUS_WIDTH-1:0]  sync_bus_q;
   logic [BUS_WIDTH-1:0]  sync_bus_d;
   logic                  enable_pulse_q;
   logic                  enable_pulse_d;
   logic                  ack_q;
   logic                  ack_d;

   // Request synchronizer: the only logic that ever samples unsync_req.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[NUM_STAGES-2:0], unsync_req};
      end
   end

   assign req_s = sync_q[NUM_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         sync_bus_q     <= '0;
         enable_pulse_q <= 1'b0;
         ack_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         sync_bus_q     <= sync_bus_d;
         enable_pulse_q <= enable_pulse_d;
         ack_q          <= ack_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (req_s) state_d = CAPTURE;
         CAPTURE:  state_d = WAIT_LOW;
         WAIT_LOW: if (!req_s) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Next-value logic for the registered outputs; the bus is loaded only on capture.
   always_comb begin
      sync_bus_d     = sync_bus_q;
      enable_pulse_d = 1'b0;
      ack_d          = ack_q;
      case (state_q)
         IDLE: begin
            if (req_s) begin
               sync_bus_d     = unsync_bus;
               enable_pulse_d = 1'b1;
               ack_d          = 1'b1;
            end
         end
         CAPTURE: begin
            ack_d = 1'b1;
         end
         WAIT_LOW: begin
            if (!req_s) ack_d = 1'b0;
         end
         default: begin
            ack_d = 1'b0;
         end
      endcase
   end

   assign sync_bus     = sync_bus_q;
   assign enable_pulse = enable_pulse_q;
   assign ack          = ack_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_handshake_data_sync.sv
// tb/tb_handshake_data_sync.sv - self-checking bench for handshake_data_sync
// Edge-indexed reference model plus directed scenarios and randomized 4-phase traffic.
module tb_handshake_data_sync;

   localparam int N = 2;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         unsync_req = 1'b0;
   logic [W-1:0] unsync_bus = '0;
   logic [W-1:0] sync_bus;
   logic         enable_pulse;
   logic         ack;
   logic         busy;

   int n_checks = 0;
   int n_pass = 0;

   handshake_data_sync #(.NUM_STAGES(N), .BUS_WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .unsync_req   (unsync_req),
      .unsync_bus   (unsync_bus),
      .sync_bus     (sync_bus),
      .enable_pulse (enable_pulse),
      .ack          (ack),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      else n_pass++;
   endtask

   // Reference model: at edge e the handshake reacts to the level sampled N edges earlier.
   // A capture raises ack; ack drops at the first edge >= capture+2 that sees a low level.
   logic         m_ack;
   logic         m_pulse;
   logic [W-1:0] m_bus;
   int           nedge;
   int           cap_edge;
   int           m_caps = 0;
   bit           hq[$];
   bit           seen;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nedge    = 0;
         cap_edge = 0;
         m_ack    = 1'b0;
         m_pulse  = 1'b0;
         m_bus    = '0;
         hq.delete();
      end else begin
         nedge++;
         hq.push_back(unsync_req);
         if (hq.size() > 8) void'(hq.pop_front());
         m_pulse = 1'b0;
         if (nedge > N) begin
            seen = hq[hq.size()-1-N];
            if (!m_ack && seen) begin
               m_ack    = 1'b1;
               m_pulse  = 1'b1;
               m_bus    = unsync_bus;
               cap_edge = nedge;
               m_caps++;
            end else if (m_ack && nedge >= cap_edge + 2 && !seen) begin
               m_ack = 1'b0;
            end
         end
      end
   end

   int           n_pulses = 0;
   logic [W-1:0] pq[$];

   always @(negedge clk) begin
      chk("cyc_ack", 32'(ack), 32'(m_ack));
      chk("cyc_pulse", 32'(enable_pulse), 32'(m_pulse));
      chk("cyc_busy", 32'(busy), 32'(m_ack));
      chk("cyc_bus", 32'(sync_bus), 32'(m_bus));
      if (enable_pulse) begin
         n_pulses++;
         pq.push_back(sync_bus);
      end
   end

   task automatic at_off(input int off);
      @(posedge clk);
      #(off);
   endtask

   task automatic wait_ack(input logic v, input string tag);
      int k = 0;
      while (ack !== v && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(ack), 32'(v));
   endtask

   task automatic transfer(input logic [W-1:0] d);
      at_off($urandom_range(1, 9));
      unsync_bus = d;
      unsync_req = 1'b1;
      wait_ack(1'b1, "xfer_ack_hi");
      at_off($urandom_range(1, 9));
      unsync_req = 1'b0;
      wait_ack(1'b0, "xfer_ack_lo");
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   initial begin
      int base_p;
      int base_q;
      int mode;
      logic [W-1:0] d;

      // Reset held with request high and bus all ones
      unsync_req = 1'b1;
      unsync_bus = 8'hFF;
      #1 rst_n = 1'b0;
      #1 chk("rst_ack_imm", 32'(ack), 32'd0);
      repeat (9) begin
         @(negedge clk);
         chk("rst_bus", 32'(sync_bus), 32'd0);
         chk("rst_pulse", 32'(enable_pulse), 32'd0);
         chk("rst_ack", 32'(ack), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
      end
      unsync_req = 1'b0;
      unsync_bus = 8'h00;
      #11 rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // Single transfer: request rises 3 ns before edge k
      @(posedge clk);
      #7;
      unsync_bus = 8'hA5;
      unsync_req = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("single_early_pulse", 32'(enable_pulse), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("single_bus", 32'(sync_bus), 32'hA5);
      chk("single_pulse", 32'(enable_pulse), 32'd1);
      chk("single_ack", 32'(ack), 32'd1);
      @(negedge clk);
      chk("single_pulse_width", 32'(enable_pulse), 32'd0);
      chk("single_ack_hold", 32'(ack), 32'd1);

      // Release: ack drops on the third edge after the request falls
      @(posedge clk);
      #7 unsync_req = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("release_ack_2", 32'(ack), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("release_ack_3", 32'(ack), 32'd0);
      chk("release_busy", 32'(busy), 32'd0);
      chk("release_bus", 32'(sync_bus), 32'hA5);

      // Back-to-back transfers
      base_p = n_pulses;
      base_q = pq.size();
      transfer(8'h3C);
      transfer(8'hC3);
      repeat (2) @(negedge clk);
      chk("b2b_count", 32'(n_pulses - base_p), 32'd2);
      chk("b2b_first", 32'(pq[base_q]), 32'h3C);
      chk("b2b_second", 32'(pq[base_q+1]), 32'hC3);

      // Bus change while ack is high must not be captured
      base_p = n_pulses;
      at_off(4);
      unsync_bus = 8'h11;
      unsync_req = 1'b1;
      wait_ack(1'b1, "busch_ack_hi");
      repeat (2) @(negedge clk);
      at_off(5);
      unsync_bus = 8'h22;
      repeat (4) @(negedge clk);
      chk("busch_bus", 32'(sync_bus), 32'h11);
      chk("busch_count", 32'(n_pulses - base_p), 32'd1);
      at_off(3);
      unsync_req = 1'b0;
      wait_ack(1'b0, "busch_ack_lo");

      // Reset in WAIT_LOW with the request held high
      at_off(6);
      unsync_bus = 8'h5A;
      unsync_req = 1'b1;
      wait_ack(1'b1, "midrst_ack_hi");
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_ack_imm", 32'(ack), 32'd0);
      chk("midrst_busy_imm", 32'(busy), 32'd0);
      chk("midrst_bus_imm", 32'(sync_bus), 32'd0);
      #22 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_e1", 32'(enable_pulse), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("midrst_e2", 32'(enable_pulse), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("midrst_e3_pulse", 32'(enable_pulse), 32'd1);
      chk("midrst_e3_bus", 32'(sync_bus), 32'h5A);
      at_off(4);
      unsync_req = 1'b0;
      wait_ack(1'b0, "midrst_ack_lo");

      // Randomized traffic: normal, one-sample pulses, and sub-period low glitches
      for (int i = 0; i < 30; i++) begin
         d = W'($urandom);
         mode = $urandom_range(0, 2);
         at_off($urandom_range(1, 9));
         unsync_bus = d;
         unsync_req = 1'b1;
         if (mode == 1) begin
            at_off($urandom_range(1, 8));
            unsync_req = 1'b0;
            wait_ack(1'b1, "rnd_short_hi");
            at_off($urandom_range(1, 9));
            unsync_bus = W'($urandom);
            wait_ack(1'b0, "rnd_short_lo");
         end else begin
            wait_ack(1'b1, "rnd_ack_hi");
            at_off($urandom_range(1, 9));
            unsync_bus = W'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            if (mode == 2) begin
               @(posedge clk);
               #2 unsync_req = 1'b0;
               #5 unsync_req = 1'b1;
               repeat (3) @(negedge clk);
               chk("rnd_glitch_ack", 32'(ack), 32'd1);
            end
            at_off($urandom_range(1, 9));
            unsync_req = 1'b0;
            wait_ack(1'b0, "rnd_ack_lo");
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (6) @(negedge clk);
      chk("total_pulses", 32'(n_pulses), 32'(m_caps));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
